csla_pipe: RTL and testbench

//  Parametrised, pipelined carry-select adder/subtractor for the complex-multiplier datapath.

---
 rtl/csla_pipe_pkg.sv | 18 +
 rtl/csla_pipe_if.sv | 26 ++
 rtl/csla_pipe_block.sv | 37 +++
 rtl/csla_pipe.sv | 112 +++++++++++
 tb/tb_csla_pipe.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/csla_pipe_pkg.sv
// Shared helpers and types for the pipelined carry-select adder/subtractor.
package csla_pipe_pkg;

    typedef struct packed {
        logic valid;
        logic carry;
        logic ovf;
    } csla_ctl_t;

    function automatic int csla_nblk(input int w, input int b);
        return (b > 0) ? w / b : 0;
    endfunction

    function automatic int csla_bps(input int nblk, input int s);
        return (s > 0) ? (nblk + s - 1) / s : 1;
    endfunction

endpackage

// File: rtl/csla_pipe_if.sv
// Operand/result handshake bundle for csla_pipe.
interface csla_pipe_if #(parameter int WIDTH = 16);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport mst (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slv (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

endinterface

// File: rtl/csla_pipe_block.sv
// One carry-select block: both ripple sums precomputed, incoming carry picks one.
module csla_block #(
    parameter int BLK = 4
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           ci,
    output logic [BLK-1:0] s,
    output logic           co
);

    logic [BLK-1:0] s0;
    logic [BLK-1:0] s1;
    logic           co0;
    logic           co1;

    always_comb begin
        logic r0;
        logic r1;
        r0 = 1'b0;
        r1 = 1'b1;
        s0 = '0;
        s1 = '0;
        for (int i = 0; i < BLK; i++) begin
            s0[i] = a[i] ^ b[i] ^ r0;
            s1[i] = a[i] ^ b[i] ^ r1;
            r0    = (a[i] & b[i]) | ((a[i] ^ b[i]) & r0);
            r1    = (a[i] & b[i]) | ((a[i] ^ b[i]) & r1);
        end
        co0 = r0;
        co1 = r1;
    end

    assign s  = ci ? s1 : s0;
    assign co = ci ? co1 : co0;

endmodule

// File: rtl/csla_pipe.sv
// Pipelined carry-select adder/subtractor: blocks split across STAGES register ranks,
// operands skewed forward with the partial sum, valid/ready on both sides.
module csla_pipe
    import csla_pipe_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int BLK    = 4,
    parameter int STAGES = 2
) (
    input logic      clk,
    input logic      rst_n,
    csla_pipe_if.slv bus
);

    localparam int NBLK = csla_nblk(WIDTH, BLK);
    localparam int BPS  = csla_bps(NBLK, STAGES);

    if (BLK < 1 || WIDTH < BLK || (WIDTH % BLK) != 0 || STAGES < 1 || STAGES > NBLK) begin : g_bad_cfg
        $error("csla_pipe: illegal WIDTH/BLK/STAGES combination");
    end

    logic                              adv;
    logic [STAGES-1:0][WIDTH-1:0]      stg_a;
    logic [STAGES-1:0][WIDTH-1:0]      stg_b;
    logic [STAGES-1:0][WIDTH-1:0]      stg_sum_i;
    logic [STAGES-1:0][WIDTH-1:0]      stg_sum_o;
    csla_ctl_t [STAGES-1:0]            stg_ctl_i;
    csla_ctl_t [STAGES-1:0]            stg_ctl_o;
    logic [STAGES-1:0][WIDTH-1:0]      rank_a;
    logic [STAGES-1:0][WIDTH-1:0]      rank_b;
    logic [STAGES-1:0][WIDTH-1:0]      rank_sum;
    csla_ctl_t [STAGES-1:0]            rank_ctl;

    // The whole pipe moves as one: any empty or drained output slot lets every rank shift.
    assign adv           = bus.out_ready | ~rank_ctl[STAGES-1].valid;
    assign bus.in_ready  = adv;
    assign bus.out_valid = rank_ctl[STAGES-1].valid;
    assign bus.sum       = rank_sum[STAGES-1];
    assign bus.cout      = rank_ctl[STAGES-1].carry;
    assign bus.ovf       = rank_ctl[STAGES-1].ovf;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int LO = s * BPS;
        localparam int HI = (((s + 1) * BPS < NBLK) ? (s + 1) * BPS : NBLK) - 1;

        logic [NBLK-1:0]  co;
        logic [WIDTH-1:0] sum_o;

        if (s == 0) begin : g_first
            assign stg_a[0]     = bus.a;
            assign stg_b[0]     = bus.sub ? ~bus.b : bus.b;
            assign stg_sum_i[0] = '0;
            assign stg_ctl_i[0] = '{valid: bus.in_valid, carry: bus.sub | bus.cin, ovf: 1'b0};
        end else begin : g_next
            assign stg_a[s]     = rank_a[s-1];
            assign stg_b[s]     = rank_b[s-1];
            assign stg_sum_i[s] = rank_sum[s-1];
            assign stg_ctl_i[s] = rank_ctl[s-1];
        end

        for (genvar k = 0; k < NBLK; k++) begin : g_blk
            if (k >= LO && k <= HI) begin : g_own
                logic ci;
                if (k == LO) begin : g_head
                    assign ci = stg_ctl_i[s].carry;
                end else begin : g_chain
                    assign ci = co[k-1];
                end
                csla_block #(.BLK(BLK)) u_blk (
                    .a  (stg_a[s][k*BLK +: BLK]),
                    .b  (stg_b[s][k*BLK +: BLK]),
                    .ci (ci),
                    .s  (sum_o[k*BLK +: BLK]),
                    .co (co[k])
                );
            end else begin : g_pass
                assign sum_o[k*BLK +: BLK] = stg_sum_i[s][k*BLK +: BLK];
                assign co[k]               = 1'b0;
            end
        end

        assign stg_sum_o[s] = sum_o;

        // Carry into the MSB is recovered from its sum bit, so ovf needs no extra tap.
        if (LO <= HI) begin : g_ctl
            assign stg_ctl_o[s] = '{
                valid: stg_ctl_i[s].valid,
                carry: co[HI],
                ovf:   (HI == NBLK - 1)
                       ? (co[NBLK-1] ^ sum_o[WIDTH-1] ^ stg_a[s][WIDTH-1] ^ stg_b[s][WIDTH-1])
                       : stg_ctl_i[s].ovf
            };
        end else begin : g_empty
            assign stg_ctl_o[s] = stg_ctl_i[s];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rank_a   <= '0;
            rank_b   <= '0;
            rank_sum <= '0;
            rank_ctl <= '0;
        end else if (adv) begin
            rank_a   <= stg_a;
            rank_b   <= stg_b;
            rank_sum <= stg_sum_o;
            rank_ctl <= stg_ctl_o;
        end
    end

endmodule

// File: tb/tb_csla_pipe.sv
// Directed and random checks of csla_pipe in several WIDTH/BLK/STAGES configurations.
module tb_csla_pipe;

    localparam int W     = 16;
    localparam int NVEC  = 13;
    localparam int NSWP  = 150;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    vec_t vecs[NVEC];
    logic [17:0] hist[NSWP];

    always #5 clk = ~clk;

    csla_pipe_if #(.WIDTH(W)) bus();
    csla_pipe_if #(.WIDTH(W)) bus_s1();
    csla_pipe_if #(.WIDTH(W)) bus_s3();
    csla_pipe_if #(.WIDTH(W)) bus_s4();

    csla_pipe #(.WIDTH(W), .BLK(4), .STAGES(2)) dut    (.clk(clk), .rst_n(rst_n), .bus(bus));
    csla_pipe #(.WIDTH(W), .BLK(8), .STAGES(1)) dut_s1 (.clk(clk), .rst_n(rst_n), .bus(bus_s1));
    csla_pipe #(.WIDTH(W), .BLK(4), .STAGES(3)) dut_s3 (.clk(clk), .rst_n(rst_n), .bus(bus_s3));
    csla_pipe #(.WIDTH(W), .BLK(2), .STAGES(4)) dut_s4 (.clk(clk), .rst_n(rst_n), .bus(bus_s4));

    function automatic logic [17:0] refModel(input logic [15:0] a, input logic [15:0] b,
                                             input logic cin, input logic sub);
        logic [15:0] bb;
        logic [16:0] t;
        logic        o;
        bb = sub ? ~b : b;
        t  = {1'b0, a} + {1'b0, bb} + {16'd0, (sub ? 1'b1 : cin)};
        o  = (a[15] == bb[15]) && (t[15] != a[15]);
        return {t[16], o, t[15:0]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input logic valid);
        bus.a        = v.a;
        bus.b        = v.b;
        bus.cin      = v.cin;
        bus.sub      = v.sub;
        bus.in_valid = valid;
    endtask

    // Single transfer into an empty pipe; checks latency and the result.
    task automatic sendOne(input int i);
        int n;
        applyStimulus(vecs[i], 1'b1);
        #1;
        checkOutput($sformatf("in_ready[%0d]", i), {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput($sformatf("latency[%0d]", i), n, 32'd1);
        checkOutput($sformatf("result[%0d]", i), {14'd0, bus.cout, bus.ovf, bus.sum},
                    {14'd0, vecs[i].cout, vecs[i].ovf, vecs[i].sum});
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        failures++;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int sent;
        int recv;
        logic stall_seen;
        logic [17:0] held;
        logic [17:0] cur;
        logic in_fire;
        logic out_fire;
        logic [5:0] bub_in;
        logic [5:0] bub_out;

        vecs[0]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[1]  = '{16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0};
        vecs[2]  = '{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[3]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[4]  = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[5]  = '{16'h0F0F, 16'h00F1, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0};
        vecs[6]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[7]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[8]  = '{16'h00FF, 16'hFF01, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[9]  = '{16'h5555, 16'hAAAA, 1'b0, 1'b1, 16'hAAAB, 1'b0, 1'b1};
        vecs[10] = '{16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[11] = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[12] = '{16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0};

        applyStimulus(vecs[0], 1'b0);
        bus.out_ready = 1'b1;
        bus_s1.in_valid = 1'b0; bus_s1.out_ready = 1'b1;
        bus_s1.a = '0; bus_s1.b = '0; bus_s1.cin = 1'b0; bus_s1.sub = 1'b0;
        bus_s3.in_valid = 1'b0; bus_s3.out_ready = 1'b1;
        bus_s3.a = '0; bus_s3.b = '0; bus_s3.cin = 1'b0; bus_s3.sub = 1'b0;
        bus_s4.in_valid = 1'b0; bus_s4.out_ready = 1'b1;
        bus_s4.a = '0; bus_s4.b = '0; bus_s4.cin = 1'b0; bus_s4.sub = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        checkOutput("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("reset_sum", {16'd0, bus.sum}, 32'd0);
        checkOutput("reset_cout_ovf", {30'd0, bus.cout, bus.ovf}, 32'd0);
        checkOutput("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);

        for (int i = 0; i < NVEC; i++) sendOne(i);

        // Six back-to-back operations with a three-cycle downstream stall.
        sent = 0; recv = 0; stall_seen = 1'b0; held = '0;
        for (int c = 0; c < 40 && recv < 6; c++) begin
            bus.out_ready = !(c >= 3 && c <= 5);
            if (sent < 6) applyStimulus(vecs[sent], 1'b1);
            else bus.in_valid = 1'b0;
            #1;
            in_fire  = bus.in_valid & bus.in_ready;
            out_fire = bus.out_valid & bus.out_ready;
            cur      = {bus.cout, bus.ovf, bus.sum};
            if (bus.out_valid && !bus.out_ready) begin
                checkOutput($sformatf("bp_in_ready[c%0d]", c), {31'd0, bus.in_ready}, 32'd0);
                if (stall_seen) checkOutput($sformatf("bp_stable[c%0d]", c), {14'd0, cur}, {14'd0, held});
                held = cur;
                stall_seen = 1'b1;
            end
            if (out_fire) begin
                checkOutput($sformatf("bp_result[%0d]", recv), {14'd0, cur},
                            {14'd0, vecs[recv].cout, vecs[recv].ovf, vecs[recv].sum});
                recv++;
            end
            @(posedge clk); #1;
            if (in_fire) sent++;
        end
        checkOutput("bp_stall_seen", {31'd0, stall_seen}, 32'd1);
        checkOutput("bp_recv_count", recv, 32'd6);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Bubble pattern 1,0,1 must reappear two cycles later.
        bub_in  = 6'b000101;
        bub_out = 6'b010100;
        for (int c = 0; c < 6; c++) begin
            applyStimulus(vecs[c], bub_in[c]);
            #1;
            checkOutput($sformatf("bubble_valid[c%0d]", c), {31'd0, bus.out_valid}, {31'd0, bub_out[c]});
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Random streaming sweep across the other configurations.
        for (int t = 0; t < NSWP + 5; t++) begin
            if (t < NSWP) begin
                logic [15:0] ra;
                logic [15:0] rb;
                logic        rc;
                logic        rs;
                ra = 16'($urandom);
                rb = 16'($urandom);
                rc = 1'($urandom);
                rs = 1'($urandom);
                hist[t] = refModel(ra, rb, rc, rs);
                bus_s1.a = ra; bus_s1.b = rb; bus_s1.cin = rc; bus_s1.sub = rs; bus_s1.in_valid = 1'b1;
                bus_s3.a = ra; bus_s3.b = rb; bus_s3.cin = rc; bus_s3.sub = rs; bus_s3.in_valid = 1'b1;
                bus_s4.a = ra; bus_s4.b = rb; bus_s4.cin = rc; bus_s4.sub = rs; bus_s4.in_valid = 1'b1;
            end else begin
                bus_s1.in_valid = 1'b0;
                bus_s3.in_valid = 1'b0;
                bus_s4.in_valid = 1'b0;
            end
            #1;
            if (t < 1) checkOutput("s1_early_valid", {31'd0, bus_s1.out_valid}, 32'd0);
            else if (t - 1 < NSWP)
                checkOutput($sformatf("s1_out[%0d]", t - 1), {13'd0, bus_s1.out_valid, bus_s1.cout, bus_s1.ovf, bus_s1.sum},
                            {13'd0, 1'b1, hist[t-1]});
            if (t < 3) checkOutput($sformatf("s3_early_valid[%0d]", t), {31'd0, bus_s3.out_valid}, 32'd0);
            else if (t - 3 < NSWP)
                checkOutput($sformatf("s3_out[%0d]", t - 3), {13'd0, bus_s3.out_valid, bus_s3.cout, bus_s3.ovf, bus_s3.sum},
                            {13'd0, 1'b1, hist[t-3]});
            if (t < 4) checkOutput($sformatf("s4_early_valid[%0d]", t), {31'd0, bus_s4.out_valid}, 32'd0);
            else if (t - 4 < NSWP)
                checkOutput($sformatf("s4_out[%0d]", t - 4), {13'd0, bus_s4.out_valid, bus_s4.cout, bus_s4.ovf, bus_s4.sum},
                            {13'd0, 1'b1, hist[t-4]});
            @(posedge clk); #1;
        end

        // Reset in the middle of a burst.
        for (int c = 0; c < 3; c++) begin
            applyStimulus(vecs[c + 4], 1'b1);
            @(posedge clk); #1;
        end
        checkOutput("rst_pre_valid", {31'd0, bus.out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_async_outputs", {13'd0, bus.out_valid, bus.cout, bus.ovf, bus.sum}, 32'd0);
        bus.in_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("rst_no_stale[c%0d]", c), {31'd0, bus.out_valid}, 32'd0);
        end
        sendOne(7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
